data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 SHALL have parameter LATENCY, default 10: cycles from request acceptance to ack; legal range 2..63.
REQ-002 SHALL have parameter DEPTH, default 512: number of 256-bit lines (16 KB).
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port addr_i, input, 32: byte address; line index = addr_i[5+$clog2(DEPTH)-1:5]; all other bits ignored.
REQ-006 SHALL have port data_i, input, 256: write line.
REQ-007 SHALL have port enable_i, input, 1: request valid; the requester holds it high until it sees ack_o.
REQ-008 SHALL have port write_i, input, 1: 1 = write, 0 = read; qualified by enable_i.
REQ-009 SHALL have port ack_o, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port data_o, output, 256: read line.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, BUSY, ACK.
REQ-012 IDLE: when enable_i=1 at an edge, SHALL do all of the following at that edge (acceptance edge E0):
- latch addr_i, data_i and write_i;
- clear the latency counter;
- go to BUSY.
REQ-013 BUSY: the counter SHALL increment once per edge; at the edge where it reaches LATENCY-1 (edge E0+LATENCY-1), the FSM SHALL go to ACK.
REQ-014 ACK_o SHALL be 1 exactly in the cycle following edge E0+LATENCY-1, i.e. visible LATENCY cycles after the acceptance edge, and 0 in every other cycle.
REQ-015 At the edge entering ACK, a latched write SHALL update the array line with the latched data; a latched read SHALL load data_o with the array line.
REQ-016 data_o SHALL hold its value until the next read completes; writes SHALL NOT change data_o.
REQ-017 From ACK, the next state SHALL always be IDLE; enable_i is ignored in the ACK cycle and in BUSY.
- Minimum spacing between acceptance edges is therefore LATENCY+1 cycles.
REQ-018 Input changes on addr_i, data_i or write_i after acceptance SHALL NOT affect the operation in flight.
REQ-019 The counter width SHALL be $clog2(LATENCY); the counter SHALL never wrap, because BUSY exits at LATENCY-1.
REQ-020 A read after a write to the same line SHALL return the written data.
REQ-021 Array contents SHALL be uninitialised (X) in RTL; a testbench MAY preload them hierarchically.

Reset
REQ-022 When rst_i=1, the block SHALL immediately, regardless of clk_i:
- set the state to IDLE and clear the counter;
- set ack_o=0 and data_o=0.
REQ-023 Reset asserted mid-operation (BUSY or ACK) SHALL abort the operation: no array write, no ack.
REQ-024 Reset SHALL NOT clear array contents.
REQ-025 The first acceptance edge SHALL be the first rising edge with rst_i=0 and enable_i=1.

Structure
REQ-026 The FSM state encoding and the line width (256) SHALL live in the shared CPU package, alongside the constants used by MEM_Stage.
REQ-027 The storage SHALL be a sub-module line_ram with these ports: clk, index, write enable, wdata, rdata.
- line_ram has a synchronous write and a registered read.
- The FSM, counter and request latches stay in data_memory.

Verification
REQ-028 The bench SHALL cover the following directed scenarios:
- Write then read, default parameters:
  - write 256'hA5...A5 to addr 0x0000_0020; ack_o SHALL rise exactly 10 cycles after acceptance;
  - read addr 0x0000_0020; data_o SHALL equal 256'hA5...A5 in the ack cycle.
- Alias: write 0xDEAD... to 0x0000_0040, then read 0x0000_4040 (bit 14 set, outside the index); the read SHALL return 0xDEAD....
- Inputs changed in BUSY:
  - accept a read of line 3, then change addr_i to line 7 in cycle 2;
  - data_o SHALL equal line 3 contents.
- Back-to-back: enable_i held high continuously for two requests:
  - acceptances SHALL be 11 cycles apart;
  - exactly two ack pulses SHALL occur, each 1 cycle wide.
- Reset mid-BUSY: assert rst_i 5 cycles after accepting a write of 0x1234... to line 9:
  - ack_o SHALL stay 0;
  - a later read of line 9 SHALL return the old value.
- LATENCY=2: the write-then-read test SHALL ack 2 cycles after acceptance.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared CPU package: cache-line geometry, data memory FSM encoding
// and the constants the MEM stage uses to talk to the data memory.
package data_memory_pkg;

   localparam int MEM_ADDR_W    = 32;
   localparam int LINE_W        = 256;
   localparam int LINE_OFFSET_W = 5;
   localparam int MEM_LATENCY   = 10;
   localparam int MEM_DEPTH     = 512;

   typedef logic [LINE_W-1:0] line_t;

   typedef enum logic [1:0] {
      DM_IDLE,
      DM_BUSY,
      DM_ACK
   } dm_state_e;

endpackage

// File: rtl/data_memory_line_ram.sv
// Line storage: synchronous write, registered read.
// Contents are never reset.
module line_ram
   import data_memory_pkg::*;
#(
   parameter int DEPTH = MEM_DEPTH
) (
   input  logic                     clk,
   input  logic [$clog2(DEPTH)-1:0] index,
   input  logic                     we,
   input  line_t                    wdata,
   output line_t                    rdata
);

   line_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[index] <= wdata;
      end
      rdata <= mem[index];
   end

endmodule

// File: rtl/data_memory.sv
// Fixed-latency line memory: accepts one request, acks LATENCY
// cycles later, then returns to idle for one cycle.
module data_memory
   import data_memory_pkg::*;
#(
   parameter int LATENCY = MEM_LATENCY,
   parameter int DEPTH   = MEM_DEPTH
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [MEM_ADDR_W-1:0] addr_i,
   input  line_t                 data_i,
   input  logic                  enable_i,
   input  logic                  write_i,
   output logic                  ack_o,
   output line_t                 data_o
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(LATENCY);
   localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 2);

   dm_state_e     state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx_q;
   logic [IW-1:0] ram_idx;
   line_t         wdata_q;
   line_t         ram_rdata;
   logic          wr_q;
   logic          last;
   logic          ram_we;
   logic          unused_addr;

   assign unused_addr = ^{addr_i[MEM_ADDR_W-1:LINE_OFFSET_W+IW],
                          addr_i[LINE_OFFSET_W-1:0]};

   assign last   = (state == DM_BUSY) && (cnt == CNT_LAST);
   assign ram_we = last && wr_q;

   // Address the RAM from the live input while idle so the registered
   // read is already valid one edge after acceptance (LATENCY=2 case).
   assign ram_idx = (state == DM_IDLE) ?
                    addr_i[LINE_OFFSET_W +: IW] : idx_q;

   line_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk_i),
      .index (ram_idx),
      .we    (ram_we),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= DM_IDLE;
         cnt     <= '0;
         ack_o   <= 1'b0;
         data_o  <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
      end else begin
         unique case (state)
            DM_IDLE: begin
               ack_o <= 1'b0;
               if (enable_i) begin
                  idx_q   <= addr_i[LINE_OFFSET_W +: IW];
                  wdata_q <= data_i;
                  wr_q    <= write_i;
                  cnt     <= '0;
                  state   <= DM_BUSY;
               end
            end
            DM_BUSY: begin
               cnt <= cnt + CW'(1);
               if (last) begin
                  state <= DM_ACK;
                  ack_o <= 1'b1;
                  if (!wr_q) begin
                     data_o <= ram_rdata;
                  end
               end
            end
            DM_ACK: begin
               ack_o <= 1'b0;
               state <= DM_IDLE;
            end
            default: begin
               ack_o <= 1'b0;
               state <= DM_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Random + directed bench for data_memory at LATENCY 10 and 2,
// checked every cycle against an edge-count behavioural model.
module tb_data_memory;
   import data_memory_pkg::*;

   localparam int LAT0 = 10;
   localparam int LAT1 = 2;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic [31:0] addr  = '0;
   line_t       wdata = '0;
   logic        wr    = 1'b0;
   logic [1:0]  en    = '0;
   logic [1:0]  ack;
   line_t       dout [2];

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   bit chk_on  = 1'b0;

   line_t mm [2][512];
   bit    pend [2];
   int    done_at [2];
   int    free_at [2];
   int    last_acc [2];
   int    prev_acc [2];
   logic  m_ack [2];
   line_t m_data [2];
   logic  r_wr [2];
   int    r_idx [2];
   line_t r_data [2];
   int    ack_hi [2];
   int    ack_rise [2];
   logic  ack_prev [2];

   data_memory #(.LATENCY(LAT0), .DEPTH(512)) dut0 (
      .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata),
      .enable_i(en[0]), .write_i(wr), .ack_o(ack[0]), .data_o(dout[0])
   );

   data_memory #(.LATENCY(LAT1), .DEPTH(512)) dut1 (
      .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(wdata),
      .enable_i(en[1]), .write_i(wr), .ack_o(ack[1]), .data_o(dout[1])
   );

   always #5 clk = ~clk;

   function automatic int lat_of(input int k);
      return (k == 0) ? LAT0 : LAT1;
   endfunction

   function automatic line_t rand_line();
      line_t v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         pend[k]    = 1'b0;
         free_at[k] = 0;
         m_ack[k]   = 1'b0;
         m_data[k]  = '0;
      end
   endtask

   // Edge n: a request accepted at edge a completes at a+L-1 and the
   // memory may accept again from edge a+L+1.
   task automatic model_step(input int n);
      for (int k = 0; k < 2; k++) begin
         m_ack[k] = 1'b0;
         if (pend[k] && n == done_at[k]) begin
            pend[k]  = 1'b0;
            m_ack[k] = 1'b1;
            if (r_wr[k]) mm[k][r_idx[k]] = r_data[k];
            else         m_data[k]       = mm[k][r_idx[k]];
         end else if (!pend[k] && n >= free_at[k] && en[k]) begin
            pend[k]     = 1'b1;
            prev_acc[k] = last_acc[k];
            last_acc[k] = n;
            done_at[k]  = n + lat_of(k) - 1;
            free_at[k]  = n + lat_of(k) + 1;
            r_wr[k]     = wr;
            r_idx[k]    = int'(addr[13:5]);
            r_data[k]   = wdata;
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) model_reset();
      else     model_step(cyc);
   end

   initial forever begin
      @(posedge rst);
      model_reset();
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("ack%0d", k), 256'(ack[k]), 256'(m_ack[k]));
            chk($sformatf("data%0d", k), dout[k], m_data[k]);
            if (ack[k] === 1'b1) begin
               ack_hi[k]++;
               if (ack_prev[k] !== 1'b1) ack_rise[k]++;
            end
            ack_prev[k] = ack[k];
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_ack(input int k, output int e);
      int t;
      e = -1;
      t = 0;
      while (e < 0 && t <= 100) begin
         @(posedge clk);
         #2;
         t++;
         if (ack[k] === 1'b1) e = cyc;
      end
      if (e < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL ack_timeout%0d: no ack in %0d cycles, required one", k, t);
      end
   endtask

   // Called at posedge+2; acceptance is the next edge; mode 1
   // scrambles inputs while busy, mode 2 moves addr_i to line 7.
   task automatic do_op(input int k, input logic w, input logic [31:0] a,
                        input line_t d, input int mode,
                        output int lat, output line_t rd);
      int acc;
      int t;
      bit done;
      addr  = a;
      wdata = d;
      wr    = w;
      en[k] = 1'b1;
      acc   = cyc + 1;
      t     = 0;
      done  = 1'b0;
      lat   = -1;
      rd    = '0;
      while (!done) begin
         @(posedge clk);
         #2;
         t++;
         if (ack[k] === 1'b1) begin
            done = 1'b1;
            lat  = cyc + 1 - acc;
            rd   = dout[k];
         end else if (t > 100) begin
            done = 1'b1;
            n_tests++;
            n_fail++;
            $display("FAIL op_timeout%0d: no ack in %0d cycles, required %0d",
                     k, t, lat_of(k));
         end else if (mode == 1) begin
            addr  = $urandom;
            wdata = rand_line();
            wr    = 1'($urandom % 2);
         end else if (mode == 2 && t == 2) begin
            addr = 32'h0000_00E0;
         end
      end
      en[k] = 1'b0;
      step(1);
   endtask

   initial begin
      line_t       rd;
      line_t       pa5, pdead, pl3, pl7, pb2b, p55, p1234;
      int          lat, a1, a2, h0, r0, k, ln;
      logic [31:0] ra;
      pa5   = {32{8'hA5}};
      pdead = {8{32'hDEAD_BEEF}};
      pl3   = {32{8'h33}};
      pl7   = {32{8'h77}};
      pb2b  = {8{32'hB2B0_0B2B}};
      p55   = {32{8'h55}};
      p1234 = {16{16'h1234}};
      for (int i = 0; i < 2; i++) begin
         ack_hi[i]   = 0;
         ack_rise[i] = 0;
         ack_prev[i] = 1'b0;
         last_acc[i] = 0;
         prev_acc[i] = 0;
      end

      @(posedge clk);
      #2;
      chk_on = 1'b1;
      step(2);
      chk("reset_ack0", 256'(ack[0]), 256'(0));
      chk("reset_data0", dout[0], '0);
      chk("reset_ack1", 256'(ack[1]), 256'(0));
      chk("reset_data1", dout[1], '0);
      rst = 1'b0;

      for (int l = 0; l < 32; l++) begin
         for (int j = 0; j < 2; j++) begin
            do_op(j, 1'b1, 32'(l) << 5, rand_line(), 0, lat, rd);
         end
      end

      do_op(0, 1'b1, 32'h0000_0020, pa5, 0, lat, rd);
      chk("wr_lat10", 256'(lat), 256'(10));
      do_op(0, 1'b0, 32'h0000_0020, '0, 0, lat, rd);
      chk("rd_lat10", 256'(lat), 256'(10));
      chk("rd_a5", rd, pa5);

      do_op(0, 1'b1, 32'h0000_0040, pdead, 0, lat, rd);
      do_op(0, 1'b0, 32'h0000_4040, '0, 0, lat, rd);
      chk("alias", rd, pdead);

      do_op(0, 1'b1, 32'h0000_0060, pl3, 0, lat, rd);
      do_op(0, 1'b1, 32'h0000_00E0, pl7, 0, lat, rd);
      do_op(0, 1'b0, 32'h0000_0060, '0, 2, lat, rd);
      chk("busy_inputs", rd, pl3);

      h0    = ack_hi[0];
      r0    = ack_rise[0];
      addr  = 32'h0000_00A0;
      wdata = pb2b;
      wr    = 1'b1;
      en[0] = 1'b1;
      wait_ack(0, a1);
      wr = 1'b0;
      wait_ack(0, a2);
      rd    = dout[0];
      en[0] = 1'b0;
      step(1);
      chk("b2b_ack_gap", 256'(a2 - a1), 256'(11));
      chk("b2b_acc_gap", 256'(last_acc[0] - prev_acc[0]), 256'(11));
      chk("b2b_pulses", 256'(ack_rise[0] - r0), 256'(2));
      chk("b2b_width", 256'(ack_hi[0] - h0), 256'(2));
      chk("b2b_data", rd, pb2b);

      do_op(0, 1'b1, 32'h0000_0120, p55, 0, lat, rd);
      h0    = ack_hi[0];
      addr  = 32'h0000_0120;
      wdata = p1234;
      wr    = 1'b1;
      en[0] = 1'b1;
      step(6);
      rst   = 1'b1;
      en[0] = 1'b0;
      step(2);
      rst = 1'b0;
      step(12);
      chk("rst_no_ack", 256'(ack_hi[0] - h0), 256'(0));
      do_op(0, 1'b0, 32'h0000_0120, '0, 0, lat, rd);
      chk("rst_old_data", rd, p55);

      do_op(1, 1'b1, 32'h0000_0020, pa5, 0, lat, rd);
      chk("l2_wr_lat", 256'(lat), 256'(2));
      do_op(1, 1'b0, 32'h0000_0020, '0, 0, lat, rd);
      chk("l2_rd_lat", 256'(lat), 256'(2));
      chk("l2_rd_a5", rd, pa5);

      for (int i = 0; i < 300; i++) begin
         k  = int'($urandom % 2);
         ln = int'($urandom % 32);
         ra = ($urandom & 32'hFFFF_C01F) | (32'(ln) << 5);
         do_op(k, 1'($urandom % 2), ra, rand_line(),
               int'($urandom % 2), lat, rd);
         chk($sformatf("rand_lat%0d", k), 256'(lat), 256'(lat_of(k)));
         step(int'($urandom % 3));
      end

      step(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
